// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched
// combinationally by index from an external key store.

module aes_sbox (
    input  logic       encrypt,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(b, b);
        x3   = gf_mul(x2, b);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    always_comb begin
        if (encrypt) dout = affine(gf_inv(din));
        else         dout = gf_inv(inv_affine(din));
    end
endmodule

module aes_inv_round_engine #(
    parameter int NR   = 10,
    parameter int IDXW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_data,
    output logic [IDXW-1:0] rk_idx,
    input  logic [127:0]    rk_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data
);
    localparam logic [IDXW-1:0] NR_IDX   = IDXW'(NR);
    localparam logic [IDXW-1:0] LAST_CNT = IDXW'(NR - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [127:0]    state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [IDXW-1:0] rk_idx_q, rk_idx_d;

    logic [7:0]      sr_byte [16];
    logic [7:0]      sb_byte [16];
    logic [127:0]    sub_vec;
    logic [127:0]    key_added;
    logic [127:0]    mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Circulant [0e 0b 0d 09] built from the 2x/4x/8x doubling chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                             ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return res;
    endfunction

    // Byte i sits at row i%4, column i/4; InvShiftRows pulls row r from column c-r.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int COL = i / 4;
        localparam int ROW = i % 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
        assign sr_byte[i] = state_q[127-8*SRC -: 8];
        aes_sbox u_sbox (
            .encrypt (1'b0),
            .din     (sr_byte[i]),
            .dout    (sb_byte[i])
        );
        assign sub_vec[127-8*i -: 8] = sb_byte[i];
    end

    assign key_added = sub_vec ^ rk_data;
    assign mixed     = inv_mix(key_added);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = in_data ^ rk_data;
                    cnt_d   = LAST_CNT;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = key_added;
                    fsm_d   = DONE;
                end else begin
                    state_d = mixed;
                    cnt_d   = cnt_q - IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        // Handshake and key-index outputs are registered from the next state.
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        rk_idx_d    = (fsm_d == RUN) ? cnt_d : NR_IDX;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rk_idx_q    <= NR_IDX;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            rk_idx_q    <= rk_idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign rk_idx    = rk_idx_q;
    assign out_data  = state_q;
endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Directed bench for aes_inv_round_engine: FIPS-197 C.1, backpressure,
// back-to-back, mid-job reset, an NR=1 build and a randomized round-trip run.

module tb_aes_inv_round_engine;
    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, in_ready, out_valid;
    logic [127:0] in_data, out_data, rk_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk [0:15];
    logic         in_valid1, out_ready1, in_ready1, out_valid1;
    logic [127:0] in_data1, out_data1, rk_data1;
    logic [3:0]   rk_idx1;
    logic [127:0] rk1 [0:15];
    logic [7:0]   isb_t [0:255];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk_data  = rk[rk_idx];
    assign rk_data1 = rk1[rk_idx1];

    aes_inv_round_engine #(.NR(10), .IDXW(4)) dut (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

    aes_inv_round_engine #(.NR(1), .IDXW(4)) dut1 (
        .CLK(clk), .RST(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .rk_idx(rk_idx1), .rk_data(rk_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_HEX[2047-8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 0; aa = a; bb = b;
        while (bb != 0) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isb_t[s[127-8*i -: 8]] : sb(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
                o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(m[k], s[127-8*(4*c+(r+k)%4) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= nr; r++) begin
            s = shift_rows(sub_bytes(s, 0), 0);
            if (r != nr) s = mix_cols(s, 0);
            s ^= rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] dec(input logic [127:0] ct, input int nr);
        logic [127:0] s;
        s = ct ^ rk[nr];
        for (int r = nr - 1; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1), 1) ^ rk[r];
            if (r != 0) s = mix_cols(s, 1);
        end
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_job(input logic [127:0] ct, input logic [127:0] exp,
                          input int stall, input string tag);
        int n;
        in_data = ct; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, " accept"}, 128'(in_ready), 128'(1));
        check({tag, " rk_idx first"}, 128'(rk_idx), 128'(10));
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            check({tag, " rk_idx run"}, 128'(rk_idx), 128'(10 - n));
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(11));
        check({tag, " out_data"}, out_data, exp);
        check({tag, " in_ready done"}, 128'(in_ready), 128'(0));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 128'(out_valid), 128'(1));
            check({tag, " hold data"}, out_data, exp);
            check({tag, " hold in_ready"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid drop"}, 128'(out_valid), 128'(0));
        check({tag, " in_ready back"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t0, t1, gap;
        bit seen, done;
        logic [127:0] ct, pt, exp;

        for (int i = 0; i < 256; i++) isb_t[sb(8'(i))] = 8'(i);
        for (int i = 0; i < 16; i++) begin rk[i] = '0; rk1[i] = '0; end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; in_data1 = '0;
        expand_key(C1_KEY);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst in_ready", 128'(in_ready), 128'(1));
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst out_data", out_data, 128'(0));
        check("rst rk_idx", 128'(rk_idx), 128'(10));
        check("rst nr1 rk_idx", 128'(rk_idx1), 128'(1));

        do_job(C1_CT, C1_PT, 0, "c1");
        do_job(C1_CT, C1_PT, 5, "backpressure");

        // Back-to-back with in_valid held high.
        in_data = C1_CT; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        t0 = cyc;
        @(negedge clk);
        in_data = '0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        check("b2b first", out_data, C1_PT);
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        t1 = cyc;
        check("b2b spacing", 128'(t1 - t0), 128'(12));
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        check("b2b second", out_data, dec(128'h0, 10));
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b no dup", 128'(out_valid), 128'(0));

        // Reset in the middle of a job.
        in_data = C1_CT; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin @(negedge clk); n++; end
        check("midrst reach cnt5", 128'(rk_idx), 128'(5));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready", 128'(in_ready), 128'(1));
        check("midrst out_valid", 128'(out_valid), 128'(0));
        check("midrst out_data", out_data, 128'(0));
        check("midrst rk_idx", 128'(rk_idx), 128'(10));
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (15) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        out_ready = 1'b0;
        check("midrst no output", 128'(seen), 128'(0));
        do_job(C1_CT, C1_PT, 0, "post_rst");

        // NR=1 build: single final round only.
        for (int j = 0; j < 3; j++) begin
            rk1[0] = rand128(); rk1[1] = rand128(); ct = rand128();
            exp = sub_bytes(shift_rows(ct ^ rk1[1], 1), 1) ^ rk1[0];
            in_data1 = ct; in_valid1 = 1'b1;
            check("nr1 in_ready", 128'(in_ready1), 128'(1));
            @(negedge clk);
            in_valid1 = 1'b0;
            check("nr1 c1 valid", 128'(out_valid1), 128'(0));
            @(negedge clk);
            check("nr1 c2 valid", 128'(out_valid1), 128'(1));
            check("nr1 data", out_data1, exp);
            @(negedge clk);
        end

        // Random round trips with valid/ready jitter.
        for (int j = 0; j < 1000; j++) begin
            for (int r = 0; r <= 10; r++) rk[r] = rand128();
            pt = rand128();
            ct = enc(pt, 10);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            in_data = ct; in_valid = 1'b1; out_ready = 1'b0;
            n = 0;
            while (!in_ready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
            in_valid = 1'b0;
            in_data = rand128();
            done = 1'b0;
            n = 0;
            while (!done && n < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check("rand data", out_data, pt);
                    done = 1'b1;
                end
                @(negedge clk);
                n++;
            end
            out_ready = 1'b0;
            check("rand delivered", 128'(done), 128'(1));
            check("rand no dup", 128'(out_valid), 128'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
